dpll_lock_ctrl: RTL and testbench

DPLL_LOCK_CTRL -- requirements
Module: dpll_lock_ctrl

---
 rtl/dpll_pkg.sv | 20 ++
 rtl/dpll_sat_counter.sv | 34 +++
 rtl/dpll_lock_ctrl.sv | 147 ++++++++++++++
 tb/tb_dpll_lock_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dpll_pkg.sv
// Shared types and constants for the DPLL lock controller.
package dpll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_ACQUIRE = 2'd2,
    ST_LOCK    = 2'd3
  } dpll_state_e;

  localparam logic [15:0] CTRL_RAIL_POS = 16'h7FFF;
  localparam logic [15:0] CTRL_RAIL_NEG = 16'h8000;
  localparam int unsigned RELOCK_W      = 8;

  // True when the LPF control word sits at either saturation rail.
  function automatic logic at_rail(input logic [15:0] word);
    return (word == CTRL_RAIL_POS) || (word == CTRL_RAIL_NEG);
  endfunction

endpackage

// File: rtl/dpll_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module dpll_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dpll_lock_ctrl.sv
// DPLL lock supervisor: settles the loop, qualifies lock from PFD activity,
// detects loss of lock and flags acquisition timeouts and control-rail hits.
module dpll_lock_ctrl
  import dpll_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES   = 64,
  parameter int unsigned UNLOCK_ERRS   = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned ACQ_TIMEOUT   = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                down,
  input  logic signed [15:0]  control,
  output logic                loop_rst,
  output logic                locked,
  output logic                lock_lost,
  output logic                acq_timeout,
  output logic                ctrl_rail,
  output logic [1:0]          state,
  output logic [RELOCK_W-1:0] relock_cnt
);

  localparam int unsigned CLEAN_W  = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned ERR_W    = $clog2(UNLOCK_ERRS + 1);
  localparam int unsigned TMO_W    = $clog2(ACQ_TIMEOUT + 1);
  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);

  dpll_state_e state_q, state_d;
  logic loop_rst_q, loop_rst_d;
  logic locked_q, locked_d;
  logic lock_lost_q, lock_lost_d;
  logic acq_timeout_q, acq_timeout_d;
  logic ctrl_rail_q, ctrl_rail_d;

  logic [CLEAN_W-1:0]  clean_cnt;
  logic [ERR_W-1:0]    err_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [SETTLE_W-1:0] settle_cnt;

  logic clean_c;
  logic settle_clr, clean_clr, tmo_clr, err_clr, relock_clr, relock_inc;
  logic settle_done, lock_hit, tmo_hit, unlock_hit;

  // Counters are held clear outside the state that owns them, so every
  // state is entered with its counters already at zero.
  always_comb begin
    clean_c     = ~up & ~down;
    settle_clr  = ~en | (state_q != ST_SETTLE);
    clean_clr   = ~en | (state_q != ST_ACQUIRE) | ~clean_c;
    tmo_clr     = ~en | (state_q != ST_ACQUIRE);
    err_clr     = ~en | (state_q != ST_LOCK) | clean_c;
    relock_clr  = ~en | (state_q == ST_IDLE);
    settle_done = (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1));
    lock_hit    = clean_c && (clean_cnt == CLEAN_W'(LOCK_CYCLES - 1));
    tmo_hit     = (tmo_cnt == TMO_W'(ACQ_TIMEOUT - 1));
    unlock_hit  = !clean_c && (err_cnt == ERR_W'(UNLOCK_ERRS - 1));
    relock_inc  = en && (state_q == ST_LOCK) && unlock_hit;
  end

  dpll_sat_counter #(.W(SETTLE_W)) u_settle_cnt (
    .clk(clk), .rst(rst), .clr(settle_clr), .inc(1'b1), .cnt(settle_cnt)
  );

  dpll_sat_counter #(.W(CLEAN_W)) u_clean_cnt (
    .clk(clk), .rst(rst), .clr(clean_clr), .inc(1'b1), .cnt(clean_cnt)
  );

  dpll_sat_counter #(.W(TMO_W)) u_tmo_cnt (
    .clk(clk), .rst(rst), .clr(tmo_clr), .inc(1'b1), .cnt(tmo_cnt)
  );

  dpll_sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk(clk), .rst(rst), .clr(err_clr), .inc(1'b1), .cnt(err_cnt)
  );

  dpll_sat_counter #(.W(RELOCK_W)) u_relock_cnt (
    .clk(clk), .rst(rst), .clr(relock_clr), .inc(relock_inc), .cnt(relock_cnt)
  );

  // Next-state and registered-output logic; en=0 overrides every transition.
  always_comb begin
    state_d       = state_q;
    acq_timeout_d = acq_timeout_q;
    lock_lost_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        acq_timeout_d = 1'b0;
        state_d       = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_done) state_d = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (lock_hit) begin
          state_d = ST_LOCK;
        end else if (tmo_hit) begin
          state_d       = ST_SETTLE;
          acq_timeout_d = 1'b1;
        end
      end
      ST_LOCK: begin
        if (unlock_hit) begin
          state_d     = ST_ACQUIRE;
          lock_lost_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!en) begin
      state_d       = ST_IDLE;
      acq_timeout_d = 1'b0;
      lock_lost_d   = 1'b0;
    end
    loop_rst_d  = (state_d == ST_IDLE) || (state_d == ST_SETTLE);
    locked_d    = (state_d == ST_LOCK);
    ctrl_rail_d = at_rail(control);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      loop_rst_q    <= 1'b1;
      locked_q      <= 1'b0;
      lock_lost_q   <= 1'b0;
      acq_timeout_q <= 1'b0;
      ctrl_rail_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      loop_rst_q    <= loop_rst_d;
      locked_q      <= locked_d;
      lock_lost_q   <= lock_lost_d;
      acq_timeout_q <= acq_timeout_d;
      ctrl_rail_q   <= ctrl_rail_d;
    end
  end

  assign state       = state_q;
  assign loop_rst    = loop_rst_q;
  assign locked      = locked_q;
  assign lock_lost   = lock_lost_q;
  assign acq_timeout = acq_timeout_q;
  assign ctrl_rail   = ctrl_rail_q;

endmodule

// File: tb/tb_dpll_lock_ctrl.sv
// Bench for dpll_lock_ctrl: phase-level reference model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_dpll_lock_ctrl;

  localparam int LOCK_N   = 64;
  localparam int UNLOCK_N = 4;
  localparam int SETTLE_N = 16;
  localparam int TMO_N    = 4096;

  logic        clk = 1'b0;
  logic        rst, en, up, down;
  logic [15:0] control;
  logic        loop_rst, locked, lock_lost, acq_timeout, ctrl_rail;
  logic [1:0]  state;
  logic [7:0]  relock_cnt;

  always #5 clk = ~clk;

  dpll_lock_ctrl #(
    .LOCK_CYCLES(LOCK_N), .UNLOCK_ERRS(UNLOCK_N),
    .SETTLE_CYCLES(SETTLE_N), .ACQ_TIMEOUT(TMO_N)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .down(down), .control(control),
    .loop_rst(loop_rst), .locked(locked), .lock_lost(lock_lost),
    .acq_timeout(acq_timeout), .ctrl_rail(ctrl_rail), .state(state),
    .relock_cnt(relock_cnt)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reference model: phase name, time spent in the phase, current run length.
  int m_state, m_phase, m_run, m_relock;
  int m_loop_rst, m_locked, m_lost, m_to, m_rail;
  bit model_valid = 1'b0;

  always @(posedge clk) begin : model
    int s, ph, run, rl, to_f, lost, rail;
    if (rst) begin
      m_state <= 0; m_phase <= 0; m_run <= 0; m_relock <= 0;
      m_loop_rst <= 1; m_locked <= 0; m_lost <= 0; m_to <= 0; m_rail <= 0;
      model_valid <= 1'b1;
    end else begin
      s = m_state; ph = m_phase; run = m_run; rl = m_relock; to_f = m_to;
      lost = 0;
      rail = (control == 16'h7FFF || control == 16'h8000) ? 1 : 0;
      if (!en) begin
        s = 0; ph = 0; run = 0; rl = 0; to_f = 0;
      end else begin
        case (s)
          0: begin s = 1; ph = 0; end
          1: begin
            ph++;
            if (ph == SETTLE_N) begin s = 2; ph = 0; run = 0; end
          end
          2: begin
            ph++;
            run = (!up && !down) ? run + 1 : 0;
            if (run == LOCK_N) begin s = 3; run = 0; end
            else if (ph == TMO_N) begin s = 1; ph = 0; to_f = 1; end
          end
          default: begin
            run = (up || down) ? run + 1 : 0;
            if (run == UNLOCK_N) begin
              s = 2; run = 0; ph = 0; lost = 1;
              if (rl < 255) rl++;
            end
          end
        endcase
      end
      m_state <= s; m_phase <= ph; m_run <= run; m_relock <= rl; m_to <= to_f;
      m_lost <= lost; m_rail <= rail;
      m_locked   <= (s == 3) ? 1 : 0;
      m_loop_rst <= (s < 2) ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("m_state", 32'(state), 32'(m_state));
      check("m_loop_rst", 32'(loop_rst), 32'(m_loop_rst));
      check("m_locked", 32'(locked), 32'(m_locked));
      check("m_lock_lost", 32'(lock_lost), 32'(m_lost));
      check("m_acq_timeout", 32'(acq_timeout), 32'(m_to));
      check("m_ctrl_rail", 32'(ctrl_rail), 32'(m_rail));
      check("m_relock_cnt", 32'(relock_cnt), 32'(m_relock));
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_locked(input int limit, output int n);
    n = 0;
    while (!locked && n < limit) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n, k, pulses;
    rst = 1'b1; en = 1'b0; up = 1'b0; down = 1'b0; control = 16'h0000;
    repeat (2) @(posedge clk);
    step();
    check("rst_state", 32'(state), 0);
    check("rst_loop_rst", 32'(loop_rst), 1);
    check("rst_locked", 32'(locked), 0);
    check("rst_acq_timeout", 32'(acq_timeout), 0);
    check("rst_relock", 32'(relock_cnt), 0);

    // Cold acquisition with a quiet PFD.
    rst = 1'b0; en = 1'b1;
    n = 0; k = 0;
    while (state != 2'd2 && k < 100) begin
      step(); k++;
      if (state == 2'd1) n++;
    end
    check("settle_cycles", 32'(n), 16);
    check("acq_loop_rst", 32'(loop_rst), 0);
    wait_locked(200, n);
    check("lock_latency", 32'(n), 64);

    // Short error burst keeps lock; a full burst drops it.
    up = 1'b1; repeat (3) step();
    up = 1'b0; step();
    check("burst3_locked", 32'(locked), 1);
    check("burst3_state", 32'(state), 3);
    up = 1'b1; pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      pulses += int'(lock_lost);
    end
    check("unlock_state", 32'(state), 2);
    check("unlock_relock", 32'(relock_cnt), 1);
    check("unlock_loop_rst", 32'(loop_rst), 0);
    up = 1'b0; step();
    pulses += int'(lock_lost);
    check("unlock_pulses", 32'(pulses), 1);

    // Periodic PFD noise prevents lock until the acquisition timeout.
    k = 1;
    while (state == 2'd2 && k < 5000) begin
      up = (k % 10 == 0);
      step(); k++;
    end
    up = 1'b0;
    check("timeout_cycles", 32'(k), 4096);
    check("timeout_state", 32'(state), 1);
    check("timeout_flag", 32'(acq_timeout), 1);
    n = 0;
    while (state == 2'd1 && n < 100) begin
      n++; step();
    end
    check("retry_settle", 32'(n), 16);
    wait_locked(200, n);
    check("relock_latency", 32'(n), 64);
    check("timeout_sticky", 32'(acq_timeout), 1);

    // Dropping en in lock.
    en = 1'b0; step();
    check("en_off_state", 32'(state), 0);
    check("en_off_locked", 32'(locked), 0);
    check("en_off_loop_rst", 32'(loop_rst), 1);
    check("en_off_timeout", 32'(acq_timeout), 0);

    // Rail detection with one-cycle latency.
    control = 16'h8000; step(); check("rail_neg", 32'(ctrl_rail), 1);
    control = 16'h7FFF; step(); check("rail_pos", 32'(ctrl_rail), 1);
    control = 16'h0000; step(); check("rail_zero", 32'(ctrl_rail), 0);
    control = 16'h7FFE; step(); check("rail_pos_m1", 32'(ctrl_rail), 0);
    control = 16'h8001; step(); check("rail_neg_p1", 32'(ctrl_rail), 0);
    control = 16'h0000;

    // Synchronous reset mid-operation overrides en.
    en = 1'b1;
    wait_locked(200, n);
    up = 1'b1; repeat (4) step(); up = 1'b0;
    wait_locked(200, n);
    check("pre_rst_relock", 32'(relock_cnt), 1);
    rst = 1'b1; up = 1'b1; step();
    check("midrst_state", 32'(state), 0);
    check("midrst_loop_rst", 32'(loop_rst), 1);
    check("midrst_locked", 32'(locked), 0);
    check("midrst_relock", 32'(relock_cnt), 0);
    rst = 1'b0; up = 1'b0;

    // Forced lock losses saturate the relock counter.
    for (int i = 0; i < 256; i++) begin
      wait_locked(200, n);
      check("force_wait_lock", 32'(locked), 1);
      up = 1'b1; repeat (4) step(); up = 1'b0;
      if (i == 0)   check("relock_first", 32'(relock_cnt), 1);
      if (i == 254) check("relock_255", 32'(relock_cnt), 255);
    end
    check("relock_sat", 32'(relock_cnt), 255);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
